frame_buffer_reader: RTL



---
 rtl/frame_buffer_reader_if.sv | 33 +++
 rtl/frame_buffer_reader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_reader_if
// Description : Read bus between the display-side frame-buffer reader and the
//               frame-buffer RAM.
//                 ram_addr   reader -> RAM  read address
//                 ram_rd_en  reader -> RAM  read enable
//                 ram_data   RAM -> reader  3-bit {R,G,B} pixel code, valid
//                                           one cycle after ram_addr/ram_rd_en
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_buffer_reader_if #(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en;
  logic [2:0]        ram_data;

  // Reader side
  modport master (
    output ram_addr,
    output ram_rd_en,
    input  ram_data
  );

  // RAM side
  modport slave (
    input  ram_addr,
    input  ram_rd_en,
    output ram_data
  );
endinterface
`default_nettype wire

// File: rtl/frame_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_reader
// Description : Display-side reader of the 3-bit colour frame buffer.
//               Generates VGA timing, fetches the stored IMG_W x IMG_H image
//               and shows it at the top-left of the screen; the rest of the
//               active area is painted with a background colour latched once
//               per frame from bg_code.
// Ports       : clk          pixel clock
//               rst          synchronous active-high reset
//               bg_code[2:0] background colour code {R,G,B}
//               ram          frame-buffer read bus (master side)
//               vga_hsync    active-low horizontal sync
//               vga_vsync    active-low vertical sync
//               vga_r/g/b    4-bit colour outputs
//               vga_de       active-video flag
//               frame_start  one-cycle pulse at counter position (0,0)
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_reader #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [2:0]       bg_code,
  frame_buffer_reader_if.master ram,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  vga_de,
  output logic                  frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [HW-1:0] IMG_X_END  = HW'(IMG_W);
  localparam logic [HW-1:0] IMG_X_LAST = HW'(IMG_W - 1);

  localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG     = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [VW-1:0] IMG_Y_END  = VW'(IMG_H);
  localparam logic [VW-1:0] IMG_Y_LAST = VW'(IMG_H - 1);

  // Timing counters and read-address counter
  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        bg_q;

  // Stage 1: region flags aligned with the returning RAM data
  logic act1_q, img1_q, hs1_q, vs1_q;

  // Stage 2: pins
  logic       hs2_q, vs2_q, de2_q;
  logic [3:0] r2_q, g2_q, b2_q;

  logic       h_wrap, v_wrap;
  logic       in_active, in_image, hsync_raw, vsync_raw;
  logic       at_origin, last_pix;
  logic [2:0] code;

  always_comb begin
    h_wrap    = (h_q == H_LAST);
    v_wrap    = (v_q == V_LAST);
    h_d       = h_wrap ? '0 : h_q + HW'(1);
    v_d       = h_wrap ? (v_wrap ? '0 : v_q + VW'(1)) : v_q;

    in_active = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    in_image  = (h_q < IMG_X_END) && (v_q < IMG_Y_END);
    hsync_raw = !((h_q >= HS_BEG) && (h_q < HS_END));
    vsync_raw = !((v_q >= VS_BEG) && (v_q < VS_END));

    at_origin = (h_q == '0) && (v_q == '0);
    last_pix  = (h_q == IMG_X_LAST) && (v_q == IMG_Y_LAST);

    // The image is read in raster order, so a running counter reproduces
    // v*IMG_W + h. It is cleared on the wrap into (0,0) and stops on the
    // final stored pixel so it holds that address until the next frame.
    if (h_wrap && v_wrap) begin
      addr_d = '0;
    end else if (in_image && !last_pix) begin
      addr_d = addr_q + ADDR_W'(1);
    end else begin
      addr_d = addr_q;
    end

    code = img1_q ? ram.ram_data : bg_q;
  end

  // Gated by rst so the pulse is absent while the design is held in reset.
  assign frame_start   = at_origin && !rst;
  assign ram.ram_addr  = addr_q;
  assign ram.ram_rd_en = in_image;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q    <= '0;
      v_q    <= '0;
      addr_q <= '0;
      bg_q   <= 3'b111;
      act1_q <= 1'b0;
      img1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      de2_q  <= 1'b0;
      r2_q   <= 4'h0;
      g2_q   <= 4'h0;
      b2_q   <= 4'h0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      addr_q <= addr_d;
      if (frame_start) begin
        bg_q <= bg_code;
      end

      act1_q <= in_active;
      img1_q <= in_image;
      hs1_q  <= hsync_raw;
      vs1_q  <= vsync_raw;

      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      de2_q  <= act1_q;
      r2_q   <= act1_q ? {4{code[2]}} : 4'h0;
      g2_q   <= act1_q ? {4{code[1]}} : 4'h0;
      b2_q   <= act1_q ? {4{code[0]}} : 4'h0;
    end
  end

  assign vga_hsync = hs2_q;
  assign vga_vsync = vs2_q;
  assign vga_de    = de2_q;
  assign vga_r     = r2_q;
  assign vga_g     = g2_q;
  assign vga_b     = b2_q;

endmodule
`default_nettype wire
